// File: rtl/controle_exibicao_leds_pkg.sv
// Shared definitions for the LED sequence player: FSM encoding, one-hot colour
// codes and default dwell times.
package controle_exibicao_leds_pkg;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        CARREGA = 3'd1,
        ACESO   = 3'd2,
        APAGADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    localparam logic [3:0] COR_VERDE    = 4'b1000;
    localparam logic [3:0] COR_AMARELO  = 4'b0100;
    localparam logic [3:0] COR_AZUL     = 4'b0010;
    localparam logic [3:0] COR_VERMELHO = 4'b0001;
    localparam logic [3:0] COR_APAGADO  = 4'b0000;

    localparam int ADDR_W_PADRAO = 4;
    localparam int CNT_W_PADRAO  = 16;
    localparam int T_ON_PADRAO   = 500;
    localparam int T_OFF_PADRAO  = 250;

endpackage

// File: rtl/controle_exibicao_leds_if.sv
// Bus between the sequence player, the game controller, the sequence RAM and
// the one-hot->RGB converter.
interface controle_exibicao_leds_if #(
    parameter int ADDR_W = 4
);
    // Handshake: iniciar is a request that is accepted only while exibindo=0;
    // it is dropped silently otherwise. pronto is a single-cycle completion
    // pulse with no back-pressure. dado_mem must be valid combinationally for
    // the current endereco in the same cycle.
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [3:0]        dado_mem;
    logic [ADDR_W-1:0] endereco;
    logic [3:0]        codigo;
    logic              exibindo;
    logic              pronto;
    logic              erro_codigo;

    modport master (
        output iniciar, limite, dado_mem,
        input  endereco, codigo, exibindo, pronto, erro_codigo
    );

    modport slave (
        input  iniciar, limite, dado_mem,
        output endereco, codigo, exibindo, pronto, erro_codigo
    );
endinterface

// File: rtl/controle_exibicao_leds_contador_tempo.sv
// Dwell timer: counts while enabled, flags the cycle in which it sits on the
// terminal value so the owner can clear it and move on.
module contador_tempo #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             limpa,
    input  logic             habilita,
    input  logic [CNT_W-1:0] terminal,
    output logic             fim
);
    logic [CNT_W-1:0] valor;

    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            valor <= '0;
        end else if (habilita) begin
            valor <= valor + CNT_W'(1);
        end
    end

    assign fim = habilita && (valor == terminal);

endmodule

// File: rtl/controle_exibicao_leds.sv
// Plays the stored colour sequence on the RGB LED: each code lit for T_ON
// cycles followed by T_OFF blank cycles, from address 0 up to the latched limit.
module controle_exibicao_leds
    import controle_exibicao_leds_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_PADRAO,
    parameter int CNT_W  = CNT_W_PADRAO,
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    controle_exibicao_leds_if.slave  bus,
    output estado_t                  estado
);

    if (T_ON < 1 || longint'(T_ON) >= (longint'(1) << CNT_W)) begin : g_t_on_invalido
        $error("T_ON out of range for CNT_W");
    end
    if (T_OFF < 1 || longint'(T_OFF) >= (longint'(1) << CNT_W)) begin : g_t_off_invalido
        $error("T_OFF out of range for CNT_W");
    end

    function automatic logic eh_one_hot(input logic [3:0] c);
        return $onehot(c);
    endfunction

    logic [ADDR_W-1:0] limite_reg;
    logic [CNT_W-1:0]  terminal;
    logic              em_contagem;
    logic              limpa;
    logic              fim_tempo;

    // The timer only runs in the two dwell states and restarts from zero at
    // every terminal hit, so each dwell phase sees a fresh count.
    assign em_contagem = (estado == ACESO) || (estado == APAGADO);
    assign terminal    = (estado == ACESO) ? CNT_W'(T_ON - 1) : CNT_W'(T_OFF - 1);
    assign limpa       = !em_contagem || fim_tempo;

    contador_tempo #(
        .CNT_W (CNT_W)
    ) u_contador_tempo (
        .clock    (clock),
        .reset    (reset),
        .limpa    (limpa),
        .habilita (em_contagem),
        .terminal (terminal),
        .fim      (fim_tempo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= INICIAL;
            limite_reg      <= '0;
            bus.endereco    <= '0;
            bus.codigo      <= COR_APAGADO;
            bus.exibindo    <= 1'b0;
            bus.pronto      <= 1'b0;
            bus.erro_codigo <= 1'b0;
        end else begin
            bus.pronto <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (bus.iniciar) begin
                        estado          <= CARREGA;
                        limite_reg      <= bus.limite;
                        bus.endereco    <= '0;
                        bus.erro_codigo <= 1'b0;
                        bus.exibindo    <= 1'b1;
                    end
                end
                CARREGA: begin
                    // A corrupt code is blanked rather than forwarded, so the
                    // converter never sees two colours at once.
                    if (eh_one_hot(bus.dado_mem)) begin
                        bus.codigo <= bus.dado_mem;
                    end else begin
                        bus.codigo      <= COR_APAGADO;
                        bus.erro_codigo <= 1'b1;
                    end
                    estado <= ACESO;
                end
                ACESO: begin
                    if (fim_tempo) begin
                        bus.codigo <= COR_APAGADO;
                        estado     <= APAGADO;
                    end
                end
                APAGADO: begin
                    if (fim_tempo) begin
                        if (bus.endereco == limite_reg) begin
                            estado <= FIM;
                        end else begin
                            bus.endereco <= bus.endereco + ADDR_W'(1);
                            estado       <= CARREGA;
                        end
                    end
                end
                FIM: begin
                    bus.pronto   <= 1'b1;
                    bus.exibindo <= 1'b0;
                    estado       <= INICIAL;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_exibicao_leds.sv
// Directed bench for the LED sequence player with T_ON=4, T_OFF=2 and a
// combinational sequence memory model.
module tb_controle_exibicao_leds;
    import controle_exibicao_leds_pkg::*;

    localparam int ADDR_W = 4;
    localparam int T_ON   = 4;
    localparam int T_OFF  = 2;

    logic    clock = 1'b0;
    logic    reset;
    estado_t estado;
    logic [3:0] mem [16];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    controle_exibicao_leds_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.dado_mem = mem[bus.endereco];

    controle_exibicao_leds #(
        .ADDR_W (ADDR_W),
        .CNT_W  (16),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .estado (estado)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Pulse iniciar for one edge from INICIAL; the block must now be in CARREGA.
    task automatic start(input logic [3:0] lim);
        bus.limite  = lim;
        bus.iniciar = 1'b1;
        step(1);
        bus.iniciar = 1'b0;
        check("start_estado", estado, CARREGA);
        check("start_exibindo", bus.exibindo, 1);
        check("start_erro_limpo", bus.erro_codigo, 0);
        check("start_endereco", bus.endereco, 0);
    endtask

    // Entered in CARREGA; leaves one edge after the last blank cycle.
    task automatic play_elem(input logic [3:0] cod, input logic [3:0] addr, input bit perturb);
        check("carrega_endereco", bus.endereco, addr);
        check("carrega_codigo", bus.codigo, 0);
        for (int i = 0; i < T_ON; i++) begin
            step(1);
            if (perturb) begin
                bus.iniciar = (i == 0);
                if (i == 0) bus.limite = 4'd0;
            end
            check("aceso_codigo", bus.codigo, cod);
            check("aceso_estado", estado, ACESO);
            check("aceso_endereco", bus.endereco, addr);
            check("aceso_pronto", bus.pronto, 0);
        end
        for (int j = 0; j < T_OFF; j++) begin
            step(1);
            check("apagado_codigo", bus.codigo, 0);
            check("apagado_estado", estado, APAGADO);
            check("apagado_endereco", bus.endereco, addr);
        end
        step(1);
    endtask

    task automatic finish_seq(input logic [3:0] addr, input bit hold_start);
        check("fim_estado", estado, FIM);
        check("fim_pronto", bus.pronto, 0);
        check("fim_codigo", bus.codigo, 0);
        check("fim_endereco", bus.endereco, addr);
        check("fim_exibindo", bus.exibindo, 1);
        if (hold_start) bus.iniciar = 1'b1;
        step(1);
        check("pronto_pulso", bus.pronto, 1);
        check("pronto_estado", estado, INICIAL);
        check("pronto_exibindo", bus.exibindo, 0);
        check("pronto_endereco", bus.endereco, addr);
        step(1);
        check("pronto_fim_pulso", bus.pronto, 0);
        if (hold_start) begin
            check("reinicio_estado", estado, CARREGA);
            bus.iniciar = 1'b0;
        end else begin
            check("ocioso_estado", estado, INICIAL);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.limite  = '0;
        for (int k = 0; k < 16; k++) mem[k] = 4'b0000;

        // Reset held three cycles
        step(3);
        check("rst_estado", estado, INICIAL);
        check("rst_endereco", bus.endereco, 0);
        check("rst_codigo", bus.codigo, 0);
        check("rst_exibindo", bus.exibindo, 0);
        check("rst_pronto", bus.pronto, 0);
        check("rst_erro", bus.erro_codigo, 0);
        reset = 1'b0;
        step(2);
        check("ocioso_pos_rst", estado, INICIAL);
        check("ocioso_exibindo", bus.exibindo, 0);

        // Single element, then iniciar held through FIM is taken one cycle later
        mem[0] = COR_VERDE;
        mem[1] = COR_AZUL;
        start(4'd0);
        play_elem(COR_VERDE, 4'd0, 1'b0);
        finish_seq(4'd0, 1'b1);
        play_elem(COR_VERDE, 4'd0, 1'b0);
        finish_seq(4'd0, 1'b0);

        // Three elements; mem[3] is a trap for overrun past the limit
        mem[0] = COR_VERMELHO;
        mem[1] = COR_AZUL;
        mem[2] = COR_AMARELO;
        mem[3] = COR_VERDE;
        start(4'd2);
        play_elem(COR_VERMELHO, 4'd0, 1'b0);
        play_elem(COR_AZUL, 4'd1, 1'b0);
        play_elem(COR_AMARELO, 4'd2, 1'b0);
        finish_seq(4'd2, 1'b0);
        step(3);
        check("endereco_mantido", bus.endereco, 2);
        check("codigo_ocioso", bus.codigo, 0);

        // Non-one-hot code in the middle of the sequence
        mem[1] = 4'b0011;
        start(4'd2);
        play_elem(COR_VERMELHO, 4'd0, 1'b0);
        check("erro_antes", bus.erro_codigo, 0);
        play_elem(COR_APAGADO, 4'd1, 1'b0);
        check("erro_marcado", bus.erro_codigo, 1);
        play_elem(COR_AMARELO, 4'd2, 1'b0);
        finish_seq(4'd2, 1'b0);
        check("erro_persistente", bus.erro_codigo, 1);
        mem[1] = COR_AZUL;

        // iniciar and limite=0 during ACESO of element 0 are ignored
        start(4'd2);
        play_elem(COR_VERMELHO, 4'd0, 1'b1);
        play_elem(COR_AZUL, 4'd1, 1'b0);
        play_elem(COR_AMARELO, 4'd2, 1'b0);
        finish_seq(4'd2, 1'b0);

        // Reset during ACESO of element 1
        start(4'd2);
        play_elem(COR_VERMELHO, 4'd0, 1'b0);
        step(2);
        check("meio_estado", estado, ACESO);
        check("meio_codigo", bus.codigo, COR_AZUL);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rstmeio_codigo", bus.codigo, 0);
        check("rstmeio_endereco", bus.endereco, 0);
        check("rstmeio_exibindo", bus.exibindo, 0);
        check("rstmeio_estado", estado, INICIAL);
        for (int k = 0; k < 10; k++) begin
            check("rstmeio_sem_pronto", bus.pronto, 0);
            step(1);
        end
        check("rstmeio_ocioso", estado, INICIAL);
        start(4'd1);
        play_elem(COR_VERMELHO, 4'd0, 1'b0);
        play_elem(COR_AZUL, 4'd1, 1'b0);
        finish_seq(4'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
